// File: rtl/fan_timer_pkg.sv
// Shared definitions for the fan off-timer: FSM state encoding and BCD digit constants.
package fan_timer_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] BCD_ZERO = 4'd0;
   localparam logic [3:0] BCD_FIVE = 4'd5;
   localparam logic [3:0] BCD_NINE = 4'd9;

endpackage

// File: rtl/fan_timer_bcd_down_digit.sv
// One BCD countdown digit: clear > load > decrement, reloading MAX on borrow.
module bcd_down_digit
   import fan_timer_pkg::*;
#(
   parameter logic [3:0] MAX = BCD_NINE
) (
   input  logic       clk,
   input  logic       reset_p,
   input  logic       dec_en,
   input  logic       load_en,
   input  logic [3:0] load_val,
   input  logic       clear,
   output logic [3:0] digit,
   output logic       borrow_out
);

   assign borrow_out = dec_en && (digit == BCD_ZERO);

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         digit <= BCD_ZERO;
      end else if (clear) begin
         digit <= BCD_ZERO;
      end else if (load_en) begin
         digit <= load_val;
      end else if (dec_en) begin
         digit <= (digit == BCD_ZERO) ? MAX : digit - 4'd1;
      end
   end

endmodule

// File: rtl/fan_timer_bcd_down.sv
// MM:SS BCD countdown timer for the fan off-timer with load/start/pause/cancel control.
module fan_timer_bcd_down
   import fan_timer_pkg::*;
#(
   parameter logic [3:0] SEC_TENS_MAX = BCD_FIVE,
   parameter logic [3:0] DIGIT_MAX    = BCD_NINE
) (
   input  logic       clk,
   input  logic       reset_p,
   input  logic       tick_1s,
   input  logic       load,
   input  logic [7:0] load_min,
   input  logic [7:0] load_sec,
   input  logic       start,
   input  logic       pause,
   input  logic       cancel,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       running,
   output logic       done_pulse,
   output logic       expired
);

   function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] mx);
      return (d > mx) ? mx : d;
   endfunction

   state_t     state_q, state_nx;
   logic       clear_en, load_en, dec_en, done_nx;
   logic       count_is_zero, count_is_one;
   logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
   logic       b_sec_ones, b_sec_tens, b_min_ones, unused_borrow;

   assign count_is_zero = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000);
   assign count_is_one  = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0001);

   // Priority: cancel > load > start > pause > tick; an ignored start does not mask lower inputs.
   always_comb begin
      state_nx = state_q;
      clear_en = 1'b0;
      load_en  = 1'b0;
      dec_en   = 1'b0;
      done_nx  = 1'b0;
      if (cancel) begin
         clear_en = 1'b1;
         state_nx = S_IDLE;
      end else if (load) begin
         load_en  = 1'b1;
         state_nx = S_IDLE;
      end else if (start && (state_q == S_IDLE || state_q == S_PAUSE) && !count_is_zero) begin
         state_nx = S_RUN;
      end else if (pause && state_q == S_RUN) begin
         state_nx = S_PAUSE;
      end else if (tick_1s && state_q == S_RUN) begin
         dec_en = 1'b1;
         // The decremented count is 00:00 exactly when the current count is 00:01.
         if (count_is_one) begin
            state_nx = S_DONE;
            done_nx  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         state_q    <= S_IDLE;
         running    <= 1'b0;
         expired    <= 1'b0;
         done_pulse <= 1'b0;
      end else begin
         state_q    <= state_nx;
         running    <= (state_nx == S_RUN);
         expired    <= (state_nx == S_DONE);
         done_pulse <= done_nx;
      end
   end

   bcd_down_digit #(.MAX(DIGIT_MAX)) u_sec_ones (
      .clk(clk), .reset_p(reset_p), .dec_en(dec_en), .load_en(load_en),
      .load_val(clamp_digit(load_sec[3:0], DIGIT_MAX)), .clear(clear_en),
      .digit(sec_ones), .borrow_out(b_sec_ones)
   );

   bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
      .clk(clk), .reset_p(reset_p), .dec_en(b_sec_ones), .load_en(load_en),
      .load_val(clamp_digit(load_sec[7:4], SEC_TENS_MAX)), .clear(clear_en),
      .digit(sec_tens), .borrow_out(b_sec_tens)
   );

   bcd_down_digit #(.MAX(DIGIT_MAX)) u_min_ones (
      .clk(clk), .reset_p(reset_p), .dec_en(b_sec_tens), .load_en(load_en),
      .load_val(clamp_digit(load_min[3:0], DIGIT_MAX)), .clear(clear_en),
      .digit(min_ones), .borrow_out(b_min_ones)
   );

   // Count is never zero in RUN, so the top digit's borrow never fires.
   bcd_down_digit #(.MAX(DIGIT_MAX)) u_min_tens (
      .clk(clk), .reset_p(reset_p), .dec_en(b_min_ones), .load_en(load_en),
      .load_val(clamp_digit(load_min[7:4], DIGIT_MAX)), .clear(clear_en),
      .digit(min_tens), .borrow_out(unused_borrow)
   );

   assign min_bcd = {min_tens, min_ones};
   assign sec_bcd = {sec_tens, sec_ones};

endmodule

// File: tb/tb_fan_timer_bcd_down.sv
// Bench for fan_timer_bcd_down: directed scenarios plus random stimulus against a seconds-based model.
module tb_fan_timer_bcd_down;

   logic       clk = 1'b0;
   logic       reset_p = 1'b1;
   logic       tick_1s = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, cancel = 1'b0;
   logic [7:0] load_min = 8'h00, load_sec = 8'h00;
   logic [7:0] min_bcd, sec_bcd;
   logic       running, done_pulse, expired;
   logic [18:0] obs;

   int errors = 0;
   int checks = 0;

   localparam int MI = 0, MR = 1, MP = 2, MD = 3;
   int m_secs = 0;
   int m_st   = MI;
   bit m_done = 1'b0;

   fan_timer_bcd_down dut (
      .clk(clk), .reset_p(reset_p), .tick_1s(tick_1s), .load(load),
      .load_min(load_min), .load_sec(load_sec), .start(start), .pause(pause),
      .cancel(cancel), .min_bcd(min_bcd), .sec_bcd(sec_bcd), .running(running),
      .done_pulse(done_pulse), .expired(expired)
   );

   always #5 clk = ~clk;

   assign obs = {min_bcd, sec_bcd, running, done_pulse, expired};

   function automatic int cl(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic logic [7:0] bcd2(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic [18:0] exp_vec();
      return {bcd2(m_secs / 60), bcd2(m_secs % 60), 1'(m_st == MR), 1'(m_done), 1'(m_st == MD)};
   endfunction

   task automatic model_reset();
      m_secs = 0;
      m_st   = MI;
      m_done = 1'b0;
   endtask

   task automatic model_step();
      m_done = 1'b0;
      if (cancel) begin
         m_secs = 0;
         m_st   = MI;
      end else if (load) begin
         m_secs = (cl(int'(load_min[7:4]), 9) * 10 + cl(int'(load_min[3:0]), 9)) * 60
                + cl(int'(load_sec[7:4]), 5) * 10 + cl(int'(load_sec[3:0]), 9);
         m_st   = MI;
      end else if (start && (m_st == MI || m_st == MP) && m_secs != 0) begin
         m_st = MR;
      end else if (pause && m_st == MR) begin
         m_st = MP;
      end else if (tick_1s && m_st == MR) begin
         m_secs = m_secs - 1;
         if (m_secs == 0) begin
            m_st   = MD;
            m_done = 1'b1;
         end
      end
   endtask

   // Apply one cycle of inputs, advance the model at the edge, return #1 after it.
   task automatic cyc(input logic c, input logic l, input logic [7:0] lm, input logic [7:0] ls,
                      input logic s, input logic p, input logic t);
      @(negedge clk);
      cancel = c; load = l; load_min = lm; load_sec = ls; start = s; pause = p; tick_1s = t;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_cyc();
      cyc(0, 0, 8'h00, 8'h00, 0, 0, 0);
   endtask

   task automatic test_reset();
      reset_p = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_p = 1'b0;
      model_reset();
      #1;
      checks++;
      if (obs !== 19'h0) begin
         errors++;
         $display("FAIL reset: got %h expected %h", obs, 19'h0);
      end
      idle_cyc();
      checks++;
      if (obs !== exp_vec()) begin
         errors++;
         $display("FAIL reset_idle: got %h expected %h", obs, exp_vec());
      end
   endtask

   task automatic test_expire();
      cyc(0, 1, 8'h00, 8'h03, 0, 0, 0);
      cyc(0, 0, 8'h00, 8'h00, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 8'h00, 8'h00, 0, 0, 1);
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL expire_tick%0d: got %h expected %h", i, obs, exp_vec());
         end
      end
      checks++;
      if ({done_pulse, expired, running} !== 3'b110) begin
         errors++;
         $display("FAIL expire_flags: got %b expected 110", {done_pulse, expired, running});
      end
      idle_cyc();
      checks++;
      if (obs !== exp_vec() || done_pulse !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse_width: got %h expected %h", obs, exp_vec());
      end
   endtask

   task automatic test_borrow();
      cyc(0, 1, 8'h10, 8'h00, 0, 0, 0);
      cyc(0, 0, 8'h00, 8'h00, 1, 0, 0);
      cyc(0, 0, 8'h00, 8'h00, 0, 0, 1);
      checks++;
      if ({min_bcd, sec_bcd} !== 16'h0959 || obs !== exp_vec()) begin
         errors++;
         $display("FAIL borrow_1000: got %h expected %h", obs, exp_vec());
      end
      cyc(0, 1, 8'h01, 8'h00, 0, 0, 0);
      cyc(0, 0, 8'h00, 8'h00, 1, 0, 0);
      cyc(0, 0, 8'h00, 8'h00, 0, 0, 1);
      checks++;
      if ({min_bcd, sec_bcd} !== 16'h0059 || obs !== exp_vec()) begin
         errors++;
         $display("FAIL borrow_0100: got %h expected %h", obs, exp_vec());
      end
   endtask

   task automatic test_pause();
      cyc(0, 1, 8'h00, 8'h05, 0, 0, 0);
      cyc(0, 0, 8'h00, 8'h00, 1, 0, 0);
      repeat (2) cyc(0, 0, 8'h00, 8'h00, 0, 0, 1);
      cyc(0, 0, 8'h00, 8'h00, 0, 1, 1);
      checks++;
      if ({min_bcd, sec_bcd} !== 16'h0003 || running !== 1'b0 || obs !== exp_vec()) begin
         errors++;
         $display("FAIL pause_tick: got %h expected %h", obs, exp_vec());
      end
      repeat (3) cyc(0, 0, 8'h00, 8'h00, 0, 0, 1);
      checks++;
      if (obs !== exp_vec()) begin
         errors++;
         $display("FAIL paused_hold: got %h expected %h", obs, exp_vec());
      end
      cyc(0, 0, 8'h00, 8'h00, 1, 0, 0);
      cyc(0, 0, 8'h00, 8'h00, 0, 0, 1);
      checks++;
      if ({min_bcd, sec_bcd} !== 16'h0002 || obs !== exp_vec()) begin
         errors++;
         $display("FAIL resume: got %h expected %h", obs, exp_vec());
      end
   endtask

   task automatic test_clamp_start_tick();
      cyc(0, 1, 8'h99, 8'h7C, 0, 0, 0);
      checks++;
      if ({min_bcd, sec_bcd} !== 16'h9959 || obs !== exp_vec()) begin
         errors++;
         $display("FAIL clamp: got %h expected %h", obs, exp_vec());
      end
      cyc(0, 0, 8'h00, 8'h00, 1, 0, 1);
      checks++;
      if (obs !== exp_vec()) begin
         errors++;
         $display("FAIL start_with_tick: got %h expected %h", obs, exp_vec());
      end
      cyc(0, 0, 8'h00, 8'h00, 0, 0, 1);
      checks++;
      if ({min_bcd, sec_bcd} !== 16'h9958 || obs !== exp_vec()) begin
         errors++;
         $display("FAIL first_tick: got %h expected %h", obs, exp_vec());
      end
   endtask

   task automatic test_done_exit_cancel();
      cyc(0, 1, 8'h00, 8'h01, 0, 0, 0);
      cyc(0, 0, 8'h00, 8'h00, 1, 0, 0);
      cyc(0, 0, 8'h00, 8'h00, 0, 0, 1);
      cyc(0, 0, 8'h00, 8'h00, 1, 0, 1);
      checks++;
      if (expired !== 1'b1 || obs !== exp_vec()) begin
         errors++;
         $display("FAIL done_start: got %h expected %h", obs, exp_vec());
      end
      cyc(0, 1, 8'h00, 8'h10, 0, 0, 0);
      checks++;
      if (expired !== 1'b0 || obs !== exp_vec()) begin
         errors++;
         $display("FAIL done_load: got %h expected %h", obs, exp_vec());
      end
      cyc(0, 0, 8'h00, 8'h00, 1, 0, 0);
      repeat (3) cyc(0, 0, 8'h00, 8'h00, 0, 0, 1);
      cyc(1, 0, 8'h00, 8'h00, 0, 0, 1);
      checks++;
      if (obs !== 19'h0 || obs !== exp_vec()) begin
         errors++;
         $display("FAIL cancel_run: got %h expected %h", obs, exp_vec());
      end
   endtask

   task automatic test_async_reset();
      cyc(0, 1, 8'h05, 8'h30, 0, 0, 0);
      cyc(0, 0, 8'h00, 8'h00, 1, 0, 0);
      idle_cyc();
      #2;
      reset_p = 1'b1;
      model_reset();
      #1;
      checks++;
      if (obs !== 19'h0) begin
         errors++;
         $display("FAIL async_reset: got %h expected %h", obs, 19'h0);
      end
      @(negedge clk);
      reset_p = 1'b0;
      idle_cyc();
      checks++;
      if (obs !== exp_vec()) begin
         errors++;
         $display("FAIL after_reset: got %h expected %h", obs, exp_vec());
      end
   endtask

   task automatic test_random();
      logic       c, l, s, p, t;
      logic [7:0] lm, ls;
      for (int i = 0; i < 600; i++) begin
         c  = ($urandom_range(0, 99) < 2);
         l  = ($urandom_range(0, 99) < 6);
         s  = ($urandom_range(0, 99) < 15);
         p  = ($urandom_range(0, 99) < 5);
         t  = ($urandom_range(0, 99) < 60);
         lm = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 1));
         ls = 8'($urandom_range(0, 255));
         cyc(c, l, lm, ls, s, p, t);
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL random_%0d: got %h expected %h", i, obs, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_expire();
      test_borrow();
      test_pause();
      test_clamp_start_tick();
      test_done_exit_cancel();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
